cache_transfer_ctrl: RTL and testbench
======================================

Name: cache_transfer_ctrl

Overview:
- Sequences and shares one cache_data_transfer datapath between the I-cache and D-cache miss handlers.
- Arbitrates block-refill requests round-robin and drives the datapath start strobes and base address.
- Runs an optional dirty-block write-back before each D-cache refill, and signals completion or timeout per requester.
- Sits between the two cache FSMs and the shared AXI transfer block.

Parameters:
- AXI_ADDR_WIDTH, 64, width of all block addresses.
- TIMEOUT_CYCLES, 1024, maximum cycles per phase before abort; must be ≥2.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_arst  input  1  reset; asynchronous, active-low (asserted when 0).
- i_icache_req  input  1  I-cache refill request; level, held until o_icache_done.
- i_icache_addr  input  AXI_ADDR_WIDTH  I-cache refill block address.
- i_dcache_req  input  1  D-cache miss request; level, held until o_dcache_done.
- i_dcache_dirty  input  1  victim block dirty; write-back required.
- i_dcache_addr  input  AXI_ADDR_WIDTH  D-cache refill block address.
- i_dcache_wb_addr  input  AXI_ADDR_WIDTH  victim write-back block address.
- i_count_done  input  1  last beat of current block done (from transfer counter).
- o_start_read  output  1  read phase active (to transfer block).
- o_start_write  output  1  write-back phase active (to transfer block).
- o_addr_cache  output  AXI_ADDR_WIDTH  base address for current phase.
- o_grant_dcache  output  1  1 = D-cache owns datapath, 0 = I-cache; valid while o_busy.
- o_busy  output  1  state != IDLE.
- o_icache_done  output  1  one-cycle pulse: I-cache block available.
- o_dcache_done  output  1  one-cycle pulse: D-cache block available.
- o_error  output  1  one-cycle pulse coincident with done when the phase timed out.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE; o_addr_cache 0.
  - Round-robin pointer last_grant = I-cache, so D-cache wins the first tie.
  - Latched grant, dirty flag, addresses and timeout counter all 0.
- State encoding: IDLE, WB, GAP, REFILL, DONE. Registered Moore outputs.
- IDLE:
  - No request: stay.
  - One request: grant it.
  - Both requesting: grant the requester != last_grant.
  - On grant, latch the requester id, i_dcache_dirty (D-cache only, else 0), refill address and write-back address. Update last_grant.
  - Next state is WB if the latched dirty flag is 1, else REFILL.
  - Inputs changing after grant are ignored.
- WB: o_start_write=1, o_addr_cache = latched write-back address. On i_count_done=1, go to GAP.
- GAP: exactly one cycle, both starts 0. This returns the transfer block to free so its counter, address and shift register reload. Then go to REFILL.
- REFILL: o_start_read=1, o_addr_cache = latched refill address. On i_count_done=1, go to DONE.
- DONE:
  - Exactly one cycle; starts 0.
  - Pulse o_icache_done or o_dcache_done for the granted requester.
  - o_addr_cache holds its last value. Then go to IDLE.
- Latency, clean I-cache miss: req sampled in IDLE at edge 0; REFILL from edge 1; DONE the cycle after i_count_done; IDLE next.
- Latency, dirty D-cache miss: adds WB phase plus one GAP cycle.
- Requester contract: drop req on the edge after its done pulse. A req still high in the IDLE cycle after DONE is treated as a new request.
- i_count_done seen in IDLE, GAP or DONE is ignored.
- Timeout:
  - Counter clears on entry to WB or REFILL and increments each cycle in those states.
  - If it reaches TIMEOUT_CYCLES-1 without i_count_done, go directly to DONE. The done pulse is issued with o_error=1, and any remaining phase is skipped.
  - Counter width is $clog2(TIMEOUT_CYCLES)+1.
- o_grant_dcache holds the latched id from grant until the next grant; 0 after reset.
- Reset mid-operation: immediate return to reset values; no done pulse; starts drop asynchronously.
- o_start_read and o_start_write are never both 1.

Test Plan:
- I-cache only, req=1, addr=0x1000; i_count_done after 16 cycles → o_start_read high 16 cycles, o_addr_cache=0x1000, single o_icache_done pulse, o_error=0.
- D-cache dirty, wb_addr=0x2000, addr=0x3000 → write phase @0x2000, exactly one cycle both starts low, read phase @0x3000, then o_dcache_done.
- Both request simultaneously after reset → D-cache served first. I-cache held high is served next. A second simultaneous pair alternates to I-cache first.
- Never assert i_count_done, TIMEOUT_CYCLES=8 → REFILL lasts 8 cycles, then done pulse with o_error=1, back to IDLE.
- Drive i_arst=0 mid-WB → starts, o_busy and done outputs go 0 immediately. After release with no requests, stays IDLE.
- i_count_done glitched in IDLE and GAP → no state change, no done pulse.

Source files
------------

// File: rtl/cache_transfer_ctrl.sv
// Shares one block-transfer datapath between the I-cache and D-cache miss handlers:
// round-robin grant, optional dirty write-back, refill, then a done/error pulse per requester.
module cache_transfer_ctrl #(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      i_clk,
    input  logic                      i_arst,
    input  logic                      i_icache_req,
    input  logic [AXI_ADDR_WIDTH-1:0] i_icache_addr,
    input  logic                      i_dcache_req,
    input  logic                      i_dcache_dirty,
    input  logic [AXI_ADDR_WIDTH-1:0] i_dcache_addr,
    input  logic [AXI_ADDR_WIDTH-1:0] i_dcache_wb_addr,
    input  logic                      i_count_done,
    output logic                      o_start_read,
    output logic                      o_start_write,
    output logic [AXI_ADDR_WIDTH-1:0] o_addr_cache,
    output logic                      o_grant_dcache,
    output logic                      o_busy,
    output logic                      o_icache_done,
    output logic                      o_dcache_done,
    output logic                      o_error
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, WB, GAP, REFILL, DONE} state_t;

    state_t                    state_q, state_d;
    logic                      last_grant_q, last_grant_d;
    logic                      grant_q, grant_d;
    logic                      dirty_q, dirty_d;
    logic [AXI_ADDR_WIDTH-1:0] refill_addr_q, refill_addr_d;
    logic [AXI_ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
    logic [CNT_W-1:0]          cnt_q;
    logic                      pick_dcache;
    logic                      timed_out;
    logic                      error_d;

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        grant_d       = grant_q;
        dirty_d       = dirty_q;
        refill_addr_d = refill_addr_q;
        wb_addr_d     = wb_addr_q;
        pick_dcache   = 1'b0;
        error_d       = 1'b0;
        timed_out     = (cnt_q == CNT_LIMIT) && !i_count_done;

        unique case (state_q)
            IDLE: begin
                if (i_icache_req || i_dcache_req) begin
                    // On a tie the requester that was not served last time wins.
                    pick_dcache   = i_dcache_req && (!i_icache_req || !last_grant_q);
                    grant_d       = pick_dcache;
                    last_grant_d  = pick_dcache;
                    dirty_d       = pick_dcache && i_dcache_dirty;
                    refill_addr_d = pick_dcache ? i_dcache_addr : i_icache_addr;
                    wb_addr_d     = i_dcache_wb_addr;
                    state_d       = dirty_d ? WB : REFILL;
                end
            end
            WB: begin
                if (i_count_done) begin
                    state_d = GAP;
                end else if (timed_out) begin
                    state_d = DONE;
                    error_d = 1'b1;
                end
            end
            GAP: state_d = REFILL;
            REFILL: begin
                if (i_count_done) begin
                    state_d = DONE;
                end else if (timed_out) begin
                    state_d = DONE;
                    error_d = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, latched transaction fields and phase timeout counter.
    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b0;
            grant_q       <= 1'b0;
            dirty_q       <= 1'b0;
            refill_addr_q <= '0;
            wb_addr_q     <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            grant_q       <= grant_d;
            dirty_q       <= dirty_d;
            refill_addr_q <= refill_addr_d;
            wb_addr_q     <= wb_addr_d;
            if ((state_d == WB || state_d == REFILL) && state_d != state_q) begin
                cnt_q <= '0;
            end else if (state_q == WB || state_q == REFILL) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            o_start_read  <= 1'b0;
            o_start_write <= 1'b0;
            o_addr_cache  <= '0;
            o_busy        <= 1'b0;
            o_icache_done <= 1'b0;
            o_dcache_done <= 1'b0;
            o_error       <= 1'b0;
        end else begin
            o_start_read  <= (state_d == REFILL);
            o_start_write <= (state_d == WB);
            o_busy        <= (state_d != IDLE);
            o_icache_done <= (state_d == DONE) && !grant_d;
            o_dcache_done <= (state_d == DONE) && grant_d;
            o_error       <= error_d;
            if (state_d == WB) begin
                o_addr_cache <= wb_addr_d;
            end else if (state_d == REFILL) begin
                o_addr_cache <= refill_addr_d;
            end
        end
    end

    assign o_grant_dcache = grant_q;

endmodule

// File: tb/tb_cache_transfer_ctrl.sv
// Directed self-checking bench for cache_transfer_ctrl: one task per scenario,
// inputs driven and outputs sampled on the falling clock edge.
module tb_cache_transfer_ctrl;

    localparam int AW = 32;
    localparam int TO = 20;

    logic          i_clk = 1'b0;
    logic          i_arst;
    logic          i_icache_req;
    logic [AW-1:0] i_icache_addr;
    logic          i_dcache_req;
    logic          i_dcache_dirty;
    logic [AW-1:0] i_dcache_addr;
    logic [AW-1:0] i_dcache_wb_addr;
    logic          i_count_done;
    logic          o_start_read;
    logic          o_start_write;
    logic [AW-1:0] o_addr_cache;
    logic          o_grant_dcache;
    logic          o_busy;
    logic          o_icache_done;
    logic          o_dcache_done;
    logic          o_error;

    int n_checks = 0;
    int n_fail   = 0;

    cache_transfer_ctrl #(.AXI_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk(i_clk), .i_arst(i_arst),
        .i_icache_req(i_icache_req), .i_icache_addr(i_icache_addr),
        .i_dcache_req(i_dcache_req), .i_dcache_dirty(i_dcache_dirty),
        .i_dcache_addr(i_dcache_addr), .i_dcache_wb_addr(i_dcache_wb_addr),
        .i_count_done(i_count_done),
        .o_start_read(o_start_read), .o_start_write(o_start_write),
        .o_addr_cache(o_addr_cache), .o_grant_dcache(o_grant_dcache),
        .o_busy(o_busy), .o_icache_done(o_icache_done),
        .o_dcache_done(o_dcache_done), .o_error(o_error)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(negedge i_clk);
    endtask

    task automatic clear_inputs();
        i_icache_req     = 1'b0;
        i_icache_addr    = '0;
        i_dcache_req     = 1'b0;
        i_dcache_dirty   = 1'b0;
        i_dcache_addr    = '0;
        i_dcache_wb_addr = '0;
        i_count_done     = 1'b0;
    endtask

    task automatic test_reset();
        i_arst = 1'b0;
        clear_inputs();
        tick();
        n_checks++;
        if (o_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b want 0", o_busy); end
        n_checks++;
        if ({o_start_read, o_start_write} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_starts: got %b want 00", {o_start_read, o_start_write}); end
        n_checks++;
        if (o_addr_cache !== '0) begin n_fail++; $display("[TB] FAIL reset_addr: got %h want 0", o_addr_cache); end
        n_checks++;
        if ({o_grant_dcache, o_icache_done, o_dcache_done, o_error} !== 4'b0000) begin
            n_fail++; $display("[TB] FAIL reset_flags: got %b want 0000", {o_grant_dcache, o_icache_done, o_dcache_done, o_error});
        end
        i_arst = 1'b1;
        tick();
        n_checks++;
        if (o_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_release_idle: got %b want 0", o_busy); end
    endtask

    task automatic test_clean_icache();
        int rd = 0;
        int wr = 0;
        i_icache_req  = 1'b1;
        i_icache_addr = 32'h0000_1000;
        tick();
        n_checks++;
        if (o_addr_cache !== 32'h0000_1000) begin n_fail++; $display("[TB] FAIL ic_addr: got %h want 1000", o_addr_cache); end
        n_checks++;
        if (o_grant_dcache !== 1'b0) begin n_fail++; $display("[TB] FAIL ic_grant: got %b want 0", o_grant_dcache); end
        for (int i = 1; i <= 16; i++) begin
            if (o_start_read) rd++;
            if (o_start_write) wr++;
            i_count_done = (i == 16);
            tick();
        end
        i_count_done = 1'b0;
        n_checks++;
        if (rd !== 16) begin n_fail++; $display("[TB] FAIL ic_read_len: got %0d want 16", rd); end
        n_checks++;
        if (wr !== 0) begin n_fail++; $display("[TB] FAIL ic_no_write: got %0d want 0", wr); end
        n_checks++;
        if ({o_start_read, o_icache_done, o_dcache_done, o_error} !== 4'b0100) begin
            n_fail++; $display("[TB] FAIL ic_done: got rd/idone/ddone/err=%b want 0100", {o_start_read, o_icache_done, o_dcache_done, o_error});
        end
        n_checks++;
        if (o_addr_cache !== 32'h0000_1000) begin n_fail++; $display("[TB] FAIL ic_done_addr: got %h want 1000", o_addr_cache); end
        i_icache_req = 1'b0;
        tick();
        n_checks++;
        if ({o_busy, o_icache_done} !== 2'b00) begin n_fail++; $display("[TB] FAIL ic_back_idle: got busy/done=%b want 00", {o_busy, o_icache_done}); end
    endtask

    task automatic test_dirty_dcache();
        int wr = 0;
        int rd = 0;
        int both = 0;
        i_dcache_req     = 1'b1;
        i_dcache_dirty   = 1'b1;
        i_dcache_addr    = 32'h0000_3000;
        i_dcache_wb_addr = 32'h0000_2000;
        tick();
        i_dcache_dirty   = 1'b0;
        i_dcache_addr    = 32'h0000_5555;
        i_dcache_wb_addr = 32'h0000_6666;
        n_checks++;
        if ({o_start_write, o_start_read, o_grant_dcache} !== 3'b101) begin
            n_fail++; $display("[TB] FAIL dc_wb_start: got wr/rd/grant=%b want 101", {o_start_write, o_start_read, o_grant_dcache});
        end
        n_checks++;
        if (o_addr_cache !== 32'h0000_2000) begin n_fail++; $display("[TB] FAIL dc_wb_addr: got %h want 2000", o_addr_cache); end
        for (int i = 1; i <= 4; i++) begin
            if (o_start_write) wr++;
            i_count_done = (i == 4);
            tick();
        end
        n_checks++;
        if (wr !== 4) begin n_fail++; $display("[TB] FAIL dc_wb_len: got %0d want 4", wr); end
        i_count_done = 1'b1;
        n_checks++;
        if ({o_busy, o_start_write, o_start_read} !== 3'b100) begin
            n_fail++; $display("[TB] FAIL dc_gap: got busy/wr/rd=%b want 100", {o_busy, o_start_write, o_start_read});
        end
        tick();
        i_count_done = 1'b0;
        n_checks++;
        if (o_addr_cache !== 32'h0000_3000) begin n_fail++; $display("[TB] FAIL dc_refill_addr: got %h want 3000", o_addr_cache); end
        for (int i = 1; i <= 3; i++) begin
            if (o_start_read) rd++;
            if (o_start_read && o_start_write) both++;
            i_count_done = (i == 3);
            tick();
        end
        i_count_done = 1'b0;
        n_checks++;
        if (rd !== 3 || both !== 0) begin n_fail++; $display("[TB] FAIL dc_refill_len: got %0d/%0d want 3/0", rd, both); end
        n_checks++;
        if ({o_icache_done, o_dcache_done, o_error} !== 3'b010) begin
            n_fail++; $display("[TB] FAIL dc_done: got idone/ddone/err=%b want 010", {o_icache_done, o_dcache_done, o_error});
        end
        i_dcache_req = 1'b0;
        tick();
        n_checks++;
        if ({o_busy, o_dcache_done} !== 2'b00) begin n_fail++; $display("[TB] FAIL dc_back_idle: got %b want 00", {o_busy, o_dcache_done}); end
    endtask

    task automatic test_back_to_back();
        i_arst = 1'b0;
        tick();
        i_arst = 1'b1;
        i_icache_req  = 1'b1;
        i_icache_addr = 32'h0000_A000;
        i_dcache_req  = 1'b1;
        i_dcache_addr = 32'h0000_B000;
        tick();
        n_checks++;
        if ({o_grant_dcache, o_addr_cache} !== {1'b1, 32'h0000_B000}) begin
            n_fail++; $display("[TB] FAIL rr_first_d: got grant=%b addr=%h want 1/b000", o_grant_dcache, o_addr_cache);
        end
        i_count_done = 1'b1;
        tick();
        i_count_done = 1'b0;
        n_checks++;
        if ({o_icache_done, o_dcache_done} !== 2'b01) begin n_fail++; $display("[TB] FAIL rr_d_done: got %b want 01", {o_icache_done, o_dcache_done}); end
        i_dcache_req = 1'b0;
        tick();
        i_dcache_req = 1'b1;
        tick();
        n_checks++;
        if ({o_grant_dcache, o_addr_cache} !== {1'b0, 32'h0000_A000}) begin
            n_fail++; $display("[TB] FAIL rr_second_i: got grant=%b addr=%h want 0/a000", o_grant_dcache, o_addr_cache);
        end
        i_count_done = 1'b1;
        tick();
        i_count_done = 1'b0;
        n_checks++;
        if ({o_icache_done, o_dcache_done} !== 2'b10) begin n_fail++; $display("[TB] FAIL rr_i_done: got %b want 10", {o_icache_done, o_dcache_done}); end
        i_icache_req = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({o_busy, o_grant_dcache} !== 2'b11) begin n_fail++; $display("[TB] FAIL rr_third_d: got busy/grant=%b want 11", {o_busy, o_grant_dcache}); end
        i_count_done = 1'b1;
        tick();
        i_count_done = 1'b0;
        i_dcache_req = 1'b0;
        tick();
        n_checks++;
        if (o_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rr_idle: got %b want 0", o_busy); end
    endtask

    task automatic test_timeout();
        int rd = 0;
        i_icache_req  = 1'b1;
        i_icache_addr = 32'h0000_7000;
        tick();
        while (o_start_read && rd < 100) begin
            rd++;
            tick();
        end
        n_checks++;
        if (rd !== TO) begin n_fail++; $display("[TB] FAIL to_len: got %0d want %0d", rd, TO); end
        n_checks++;
        if ({o_icache_done, o_error} !== 2'b11) begin n_fail++; $display("[TB] FAIL to_done_err: got %b want 11", {o_icache_done, o_error}); end
        i_icache_req = 1'b0;
        tick();
        n_checks++;
        if ({o_busy, o_error} !== 2'b00) begin n_fail++; $display("[TB] FAIL to_idle: got busy/err=%b want 00", {o_busy, o_error}); end
    endtask

    task automatic test_reset_mid_wb();
        i_dcache_req     = 1'b1;
        i_dcache_dirty   = 1'b1;
        i_dcache_addr    = 32'h0000_3000;
        i_dcache_wb_addr = 32'h0000_2000;
        tick();
        tick();
        n_checks++;
        if (o_start_write !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_wb_active: got %b want 1", o_start_write); end
        #2 i_arst = 1'b0;
        #1;
        n_checks++;
        if ({o_start_write, o_start_read, o_busy, o_icache_done, o_dcache_done, o_error, o_grant_dcache} !== 7'b0) begin
            n_fail++; $display("[TB] FAIL mid_wb_async: got %b want 0000000",
                {o_start_write, o_start_read, o_busy, o_icache_done, o_dcache_done, o_error, o_grant_dcache});
        end
        clear_inputs();
        tick();
        i_arst = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({o_busy, o_dcache_done} !== 2'b00) begin n_fail++; $display("[TB] FAIL mid_wb_stay_idle: got %b want 00", {o_busy, o_dcache_done}); end
    endtask

    task automatic test_idle_glitch();
        i_count_done = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({o_busy, o_icache_done, o_dcache_done} !== 3'b000) begin
            n_fail++; $display("[TB] FAIL idle_glitch: got %b want 000", {o_busy, o_icache_done, o_dcache_done});
        end
        i_count_done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_icache();
        test_dirty_dcache();
        test_back_to_back();
        test_timeout();
        test_reset_mid_wb();
        test_idle_glitch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
